// File: rtl/comporta_if.sv
// Request and status bundle between the floodgate controller and its host.
// The controller takes the slave modport; the requester side takes master.
interface comporta_if #(
   parameter int POS_W = 3
);
   logic             req_local;
   logic             req_remoto;
   logic             cmd_remoto_abrir;
   logic             emergencia;
   logic [POS_W-1:0] posicao;
   logic             passo;
   logic             abrindo;
   logic             fechando;
   logic             aberta;
   logic             fechada;
   logic             ocupado;
   logic [1:0]       fonte;
   logic [3:0]       db_estado;

   modport master (
      output req_local, req_remoto, cmd_remoto_abrir, emergencia,
      input  posicao, passo, abrindo, fechando, aberta, fechada, ocupado, fonte, db_estado
   );

   modport slave (
      input  req_local, req_remoto, cmd_remoto_abrir, emergencia,
      output posicao, passo, abrindo, fechando, aberta, fechada, ocupado, fonte, db_estado
   );
endinterface

// File: rtl/comporta_controlador.sv
// Floodgate sequencing controller: arbitrates local/remote requests, steps the gate position
// and handles the emergency override. Define COMPORTA_AUTOFECHA_EN to build the ABERTA auto-close dwell.
module comporta_controlador #(
   parameter int POS_W       = 3,
   parameter int POS_MAX     = 7,
   parameter int STEP_CYCLES = 1000,
   parameter int HOLD_CYCLES = 5000
) (
   input  logic        clock,
   input  logic        reset,
   comporta_if.slave   bus
);
   typedef enum logic [3:0] {
      FECHADA    = 4'b0000,
      ABRINDO    = 4'b0001,
      ABERTA     = 4'b0010,
      FECHANDO   = 4'b0011,
      EMERGENCIA = 4'b0100
   } estado_t;

   typedef enum logic [1:0] {
      FONTE_NENHUMA = 2'b00,
      FONTE_LOCAL   = 2'b01,
      FONTE_REMOTA  = 2'b10
   } fonte_t;

   localparam int                STEP_W    = $clog2(STEP_CYCLES);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
   localparam logic [POS_W-1:0]  POS_TOP   = POS_W'(POS_MAX);

   estado_t           r_estado, w_estado_next;
   logic [POS_W-1:0]  r_posicao, w_posicao_next;
   logic [STEP_W-1:0] r_step, w_step_next;
   logic              r_passo, w_passo_next;
   fonte_t            r_fonte, w_fonte_next;

   logic w_rem_abrir;
   logic w_rem_fechar;
   logic w_step_done;

`ifdef COMPORTA_AUTOFECHA_EN
   localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

   logic [HOLD_W-1:0] r_hold, w_hold_next;
`endif

   assign w_rem_abrir  = bus.req_remoto &  bus.cmd_remoto_abrir;
   assign w_rem_fechar = bus.req_remoto & ~bus.cmd_remoto_abrir;
   assign w_step_done  = (r_step == STEP_LAST);

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado  <= FECHADA;
         r_posicao <= '0;
         r_step    <= '0;
         r_passo   <= 1'b0;
         r_fonte   <= FONTE_NENHUMA;
`ifdef COMPORTA_AUTOFECHA_EN
         r_hold    <= '0;
`endif
      end else begin
         r_estado  <= w_estado_next;
         r_posicao <= w_posicao_next;
         r_step    <= w_step_next;
         r_passo   <= w_passo_next;
         r_fonte   <= w_fonte_next;
`ifdef COMPORTA_AUTOFECHA_EN
         r_hold    <= w_hold_next;
`endif
      end
   end

   // NOTE: every variable gets a default first so no path can infer a latch.
   always_comb begin
      w_estado_next  = r_estado;
      w_posicao_next = r_posicao;
      w_passo_next   = 1'b0;
      w_fonte_next   = r_fonte;
      w_step_next    = w_step_done ? '0 : r_step + STEP_W'(1);
`ifdef COMPORTA_AUTOFECHA_EN
      w_hold_next    = '0;
`endif

      // Staying in EMERGENCIA is not a re-entry, otherwise the step timer could never advance.
      if (bus.emergencia && (r_estado inside {FECHADA, ABRINDO, ABERTA, FECHANDO})) begin
         w_estado_next = EMERGENCIA;
         w_fonte_next  = FONTE_NENHUMA;
      end else begin
         case (r_estado)
            FECHADA: begin
               w_step_next = '0;
               if (bus.req_local) begin
                  w_estado_next = ABRINDO;
                  w_fonte_next  = FONTE_LOCAL;
               end else if (w_rem_abrir) begin
                  w_estado_next = ABRINDO;
                  w_fonte_next  = FONTE_REMOTA;
               end
            end

            ABRINDO: begin
               if (w_rem_fechar) begin
                  w_estado_next = FECHANDO;
               end else if (r_posicao == POS_TOP) begin
                  w_estado_next = ABERTA;
               end else if (w_step_done) begin
                  w_posicao_next = r_posicao + POS_W'(1);
                  w_passo_next   = 1'b1;
                  if (w_posicao_next == POS_TOP) w_estado_next = ABERTA;
               end
            end

            ABERTA: begin
               w_step_next = '0;
               if (w_rem_fechar) begin
                  w_estado_next = FECHANDO;
               end else if (w_rem_abrir) begin
                  w_fonte_next = FONTE_REMOTA;
`ifdef COMPORTA_AUTOFECHA_EN
               end else if ((r_fonte == FONTE_LOCAL) && bus.req_local) begin
                  w_hold_next = '0;
               end else if (r_hold == HOLD_LAST) begin
                  w_estado_next = FECHANDO;
               end else begin
                  w_hold_next = r_hold + HOLD_W'(1);
`endif
               end
            end

            FECHANDO: begin
               if (bus.req_local) begin
                  w_estado_next = ABRINDO;
                  w_fonte_next  = FONTE_LOCAL;
               end else if (w_rem_abrir) begin
                  w_estado_next = ABRINDO;
                  w_fonte_next  = FONTE_REMOTA;
               end else if (r_posicao == '0) begin
                  w_estado_next = FECHADA;
                  w_fonte_next  = FONTE_NENHUMA;
               end else if (w_step_done) begin
                  w_posicao_next = r_posicao - POS_W'(1);
                  w_passo_next   = 1'b1;
                  if (w_posicao_next == '0) begin
                     w_estado_next = FECHADA;
                     w_fonte_next  = FONTE_NENHUMA;
                  end
               end
            end

            EMERGENCIA: begin
               w_fonte_next = FONTE_NENHUMA;
               if (r_posicao == '0) begin
                  if (!bus.emergencia) w_estado_next = FECHADA;
               end else if (w_step_done) begin
                  w_posicao_next = r_posicao - POS_W'(1);
                  w_passo_next   = 1'b1;
               end
            end

            default: begin
               w_estado_next = FECHADA;
               w_fonte_next  = FONTE_NENHUMA;
            end
         endcase
      end

      if (w_estado_next != r_estado) w_step_next = '0;
   end

   assign bus.posicao   = r_posicao;
   assign bus.passo     = r_passo;
   assign bus.abrindo   = (r_estado == ABRINDO);
   assign bus.fechando  = (r_estado == FECHANDO);
   assign bus.aberta    = (r_estado == ABERTA);
   assign bus.fechada   = (r_estado == FECHADA);
   assign bus.ocupado   = (r_estado != FECHADA);
   assign bus.fonte     = r_fonte;
   assign bus.db_estado = r_estado;
endmodule

// File: tb/tb_comporta_controlador.sv
// Scoreboard bench for comporta_controlador: directed scenarios plus randomized requests,
// each cycle checked against a motion model driven by elapsed time since state entry.
`timescale 1ns/1ps
module tb_comporta_controlador;
   localparam int POS_W = 3, POS_MAX = 3, STEP = 4, HOLD = 8;
   localparam int S_FECHADA = 0, S_ABRINDO = 1, S_ABERTA = 2, S_FECHANDO = 3, S_EMERG = 4;

   typedef struct packed {
      logic [3:0] st;
      logic [2:0] pos;
      logic       passo;
      logic [1:0] fonte;
   } exp_t;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   comporta_if #(.POS_W(POS_W)) bus ();

   comporta_controlador #(
      .POS_W(POS_W), .POS_MAX(POS_MAX), .STEP_CYCLES(STEP), .HOLD_CYCLES(HOLD)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q[$];

   logic [14:0] dut_vec;
   assign dut_vec = {bus.db_estado, bus.posicao, bus.passo, bus.abrindo, bus.fechando,
                     bus.aberta, bus.fechada, bus.ocupado, bus.fonte};

   function automatic logic [14:0] pack_exp(exp_t e);
      return {e.st, e.pos, e.passo, e.st == 4'(S_ABRINDO), e.st == 4'(S_FECHANDO),
              e.st == 4'(S_ABERTA), e.st == 4'(S_FECHADA), e.st != 4'(S_FECHADA), e.fonte};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: position is derived from the entry position plus whole steps elapsed.
   int m_st, m_pos, m_p0, m_k, m_hold, m_fonte;
   bit m_passo;

   function automatic void m_enter(int s);
      m_st = s; m_k = 0; m_p0 = m_pos; m_hold = 0;
   endfunction

   function automatic void model_reset();
      m_pos = 0; m_fonte = 0; m_passo = 0;
      m_enter(S_FECHADA);
   endfunction

   function automatic void m_move(int dir, bit em);
      int target;
      int np;
      target = (dir > 0) ? POS_MAX : 0;
      if (m_pos == target) begin
         if (m_st == S_ABRINDO) m_enter(S_ABERTA);
         else if (m_st == S_FECHANDO) begin m_enter(S_FECHADA); m_fonte = 0; end
         else if (!em) m_enter(S_FECHADA);
      end else begin
         m_k++;
         np = m_p0 + dir * (m_k / STEP);
         if (np != m_pos) begin
            m_pos = np;
            m_passo = 1;
            if (np == target && m_st == S_ABRINDO) m_enter(S_ABERTA);
            else if (np == target && m_st == S_FECHANDO) begin m_enter(S_FECHADA); m_fonte = 0; end
         end
      end
   endfunction

   function automatic void model_step(bit loc, bit rv, bit cmd, bit em);
      bit ro;
      bit rc;
      ro = rv && cmd;
      rc = rv && !cmd;
      m_passo = 0;
      if (em && m_st != S_EMERG) begin
         m_enter(S_EMERG);
         m_fonte = 0;
      end else begin
         case (m_st)
            S_FECHADA:
               if (loc) begin m_enter(S_ABRINDO); m_fonte = 1; end
               else if (ro) begin m_enter(S_ABRINDO); m_fonte = 2; end
            S_ABRINDO:
               if (rc) m_enter(S_FECHANDO);
               else m_move(1, em);
            S_ABERTA:
               if (rc) m_enter(S_FECHANDO);
               else if (ro) begin m_fonte = 2; m_hold = 0; end
`ifdef COMPORTA_AUTOFECHA_EN
               else if (m_fonte == 1 && loc) m_hold = 0;
               else begin
                  m_hold++;
                  if (m_hold == HOLD) m_enter(S_FECHANDO);
               end
`endif
            S_FECHANDO:
               if (loc) begin m_enter(S_ABRINDO); m_fonte = 1; end
               else if (ro) begin m_enter(S_ABRINDO); m_fonte = 2; end
               else m_move(-1, em);
            default: m_move(-1, em);
         endcase
      end
   endfunction

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input bit loc, input bit rv, input bit cmd, input bit em);
      exp_t e;
      bus.req_local        = loc;
      bus.req_remoto       = rv;
      bus.cmd_remoto_abrir = cmd;
      bus.emergencia       = em;
      model_step(loc, rv, cmd, em);
      e.st = 4'(m_st); e.pos = 3'(m_pos); e.passo = m_passo; e.fonte = 2'(m_fonte);
      q.push_back(e);
      @(negedge clock);
   endtask

   task automatic idle(input int n);
      repeat (n) cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic close_out(input string name);
`ifdef COMPORTA_AUTOFECHA_EN
      idle(HOLD + POS_MAX * STEP);
`else
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      idle(POS_MAX * STEP);
`endif
      check(name, {bus.fechada, bus.posicao, bus.fonte}, {1'b1, 3'd0, 2'b00});
   endtask

   task automatic open_full();
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      idle(POS_MAX * STEP);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("cycle", dut_vec, pack_exp(e));
         end
      end
   end

   initial begin : stim
      bit loc, em;
      bus.req_local = 1'b0; bus.req_remoto = 1'b0; bus.cmd_remoto_abrir = 1'b0; bus.emergencia = 1'b0;
      reset = 1'b1;
      #2;
      check("reset_outputs", dut_vec, {4'd0, 3'd0, 1'b0, 4'b0001, 1'b0, 2'b00});
      @(negedge clock);
      reset = 1'b0;
      model_reset();

      // Full local open, dwell, close.
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("open_entry", {bus.db_estado, bus.fonte}, {4'd1, 2'b01});
      idle(STEP);
      check("open_pos1", bus.posicao, 1);
      idle(2 * STEP);
      check("open_top", {bus.aberta, bus.posicao}, {1'b1, 3'd3});
      close_out("dwell_close");

      // Local beats remote in the same cycle; a held local keeps the gate open.
      cycle(1'b1, 1'b1, 1'b1, 1'b0);
      check("local_priority", bus.fonte, 2'b01);
      repeat (POS_MAX * STEP + 50) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check("hold_local", bus.aberta, 1'b1);
      close_out("hold_close");

      // Remote close mid-open, then remote reopen.
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      idle(2 * STEP);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check("rem_close", {bus.db_estado, bus.posicao}, {4'd3, 3'd2});
      idle(STEP);
      check("close_pos1", bus.posicao, 1);
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      check("reverse", {bus.db_estado, bus.fonte}, {4'd1, 2'b10});
      idle(2 * STEP);
      close_out("reverse_close");

      // Emergency from ABERTA.
      open_full();
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      check("emg_entry", {bus.db_estado, bus.fonte}, {4'd4, 2'b00});
      repeat (POS_MAX * STEP + 5) cycle(1'b1, 1'($urandom), 1'($urandom), 1'b1);
      check("emg_hold", {bus.db_estado, bus.posicao}, {4'd4, 3'd0});
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      check("emg_exit", bus.fechada, 1'b1);

`ifndef COMPORTA_AUTOFECHA_EN
      open_full();
      idle(100);
      check("no_autoclose", bus.aberta, 1'b1);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      check("manual_close", bus.db_estado, 4'd3);
      idle(POS_MAX * STEP);
`endif

      // Asynchronous reset mid-close.
      open_full();
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      idle(STEP);
      check("pre_reset_pos", bus.posicao, 2);
      reset = 1'b1;
      #1;
      check("async_reset", {bus.posicao, bus.db_estado, bus.passo, bus.fechada}, {3'd0, 4'd0, 1'b0, 1'b1});
      #1;
      reset = 1'b0;
      model_reset();

      // Randomized traffic.
      loc = 1'b0;
      em  = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(19) == 0) loc = ~loc;
         if (!em && $urandom_range(149) == 0) em = 1'b1;
         else if (em && $urandom_range(29) == 0) em = 1'b0;
         cycle(loc, $urandom_range(11) == 0, 1'($urandom), em);
      end

      check("queue_drained", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
